// File: rtl/wrchk_pkg.sv
// Shared types for the store-bus write checker: FSM states and failure causes.
package wrchk_pkg;

    localparam int ST_W = 2;
    localparam int FC_W = 2;

    typedef enum logic [ST_W-1:0] {
        IDLE,
        ARMED,
        PASS,
        FAIL
    } wrchk_state_e;

    typedef enum logic [FC_W-1:0] {
        FC_NONE,
        FC_DATA,
        FC_ADDR,
        FC_TIMEOUT
    } wrchk_fail_e;

endpackage

// File: rtl/wrchk_timeout_ctr.sv
// Saturating cycle counter for the armed window; flags the last cycle before timeout.
module wrchk_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [TW-1:0] cnt_o,
    output logic          expired_o
);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != TW'(TIMEOUT_CYCLES))) begin
            cnt_q <= cnt_q + TW'(1);
        end
    end

    assign cnt_o     = cnt_q;
    assign expired_o = (cnt_q == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/riscv_write_checker.sv
// In-order store-bus checker against a programmable (address, data) table.
// Optional WRCHK_CAPTURE_EN adds cap_addr/cap_data holding the offending store.
module riscv_write_checker
    import wrchk_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int NUM_CHECKS     = 4,
    parameter int IDXW           = $clog2(NUM_CHECKS) + 1,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            cfg_we,
    input  logic [IDXW-1:0] cfg_idx,
    input  logic [XLEN-1:0] cfg_addr,
    input  logic [XLEN-1:0] cfg_data,
    input  logic [XLEN-1:0] ign_lo,
    input  logic [XLEN-1:0] ign_hi,
    input  logic            mem_write,
    input  logic [XLEN-1:0] data_adr,
    input  logic [XLEN-1:0] write_data,
`ifdef WRCHK_CAPTURE_EN
    output logic [XLEN-1:0] cap_addr,
    output logic [XLEN-1:0] cap_data,
`endif
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            fail,
    output logic [FC_W-1:0] fail_code,
    output logic [IDXW-1:0] match_cnt,
    output logic [TW-1:0]   cycle_cnt
);

    wrchk_state_e    state_q;
    wrchk_fail_e     fail_code_q;
    logic [IDXW-1:0] match_cnt_q;
    logic            busy_q, done_q, pass_q, fail_q;

    logic [XLEN-1:0] exp_addr_q [NUM_CHECKS];
    logic [XLEN-1:0] exp_data_q [NUM_CHECKS];

`ifdef WRCHK_CAPTURE_EN
    logic [XLEN-1:0] cap_addr_q, cap_data_q;
`endif

    logic            armed, arm_go, cfg_ok;
    logic            in_ign, st_vld, addr_hit, data_hit;
    logic            st_ok, st_last, completing, st_bad_data, st_bad_addr;
    logic            expired;
    logic [XLEN-1:0] cur_addr, cur_data;

    // Mux the entry currently awaited; match_cnt never reaches NUM_CHECKS while armed.
    always_comb begin
        cur_addr = '0;
        cur_data = '0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (match_cnt_q == IDXW'(i)) begin
                cur_addr = exp_addr_q[i];
                cur_data = exp_data_q[i];
            end
        end
    end

    assign armed       = (state_q == ARMED);
    assign arm_go      = start && !armed;
    assign cfg_ok      = cfg_we && !armed;
    // An inverted window (lo > hi) can never contain an address, so it is empty.
    assign in_ign      = (data_adr >= ign_lo) && (data_adr <= ign_hi);
    assign st_vld      = armed && mem_write && !in_ign;
    assign addr_hit    = (data_adr == cur_addr);
    assign data_hit    = (write_data == cur_data);
    assign st_ok       = st_vld && addr_hit && data_hit;
    assign st_last     = (match_cnt_q == IDXW'(NUM_CHECKS - 1));
    assign completing  = st_ok && st_last;
    assign st_bad_data = st_vld && addr_hit && !data_hit;
    assign st_bad_addr = st_vld && !addr_hit;

    wrchk_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TW             (TW)
    ) u_tmo (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (arm_go),
        .en_i      (armed),
        .cnt_o     (cycle_cnt),
        .expired_o (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                exp_addr_q[i] <= '0;
                exp_data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                if (cfg_ok && (cfg_idx == IDXW'(i))) begin
                    exp_addr_q[i] <= cfg_addr;
                    exp_data_q[i] <= cfg_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            fail_code_q <= FC_NONE;
            match_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
`ifdef WRCHK_CAPTURE_EN
            cap_addr_q  <= '0;
            cap_data_q  <= '0;
`endif
        end else begin
            case (state_q)
                ARMED: begin
                    if (st_ok) begin
                        match_cnt_q <= match_cnt_q + IDXW'(1);
                    end
                    // A completing store beats the timeout on the same cycle.
                    if (completing) begin
                        state_q <= PASS;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= 1'b1;
                    end else if (expired) begin
                        state_q     <= FAIL;
                        fail_code_q <= FC_TIMEOUT;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        fail_q      <= 1'b1;
                    end else if (st_bad_data || st_bad_addr) begin
                        state_q     <= FAIL;
                        fail_code_q <= st_bad_data ? FC_DATA : FC_ADDR;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        fail_q      <= 1'b1;
`ifdef WRCHK_CAPTURE_EN
                        cap_addr_q  <= data_adr;
                        cap_data_q  <= write_data;
`endif
                    end
                end
                default: begin
                    if (start) begin
                        state_q     <= ARMED;
                        fail_code_q <= FC_NONE;
                        match_cnt_q <= '0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        fail_q      <= 1'b0;
`ifdef WRCHK_CAPTURE_EN
                        cap_addr_q  <= '0;
                        cap_data_q  <= '0;
`endif
                    end
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign fail_code = fail_code_q;
    assign match_cnt = match_cnt_q;
`ifdef WRCHK_CAPTURE_EN
    assign cap_addr  = cap_addr_q;
    assign cap_data  = cap_data_q;
`endif

endmodule

// File: tb/tb_riscv_write_checker.sv
// Bench for riscv_write_checker: directed scenarios plus random traffic vs a cycle-level model.
module tb_riscv_write_checker;

    localparam int XLEN = 32;
    localparam int NC   = 2;
    localparam int IDXW = 2;
    localparam int TO   = 16;
    localparam int TW   = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            start, cfg_we, mem_write;
    logic [IDXW-1:0] cfg_idx;
    logic [XLEN-1:0] cfg_addr, cfg_data, ign_lo, ign_hi, data_adr, write_data;
    logic            busy, done, pass, fail;
    logic [1:0]      fail_code;
    logic [IDXW-1:0] match_cnt;
    logic [TW-1:0]   cycle_cnt;
`ifdef WRCHK_CAPTURE_EN
    logic [XLEN-1:0] cap_addr, cap_data;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit              m_armed, m_pass, m_fail;
    int              m_code, m_match, m_cyc;
    logic [XLEN-1:0] m_ta [NC];
    logic [XLEN-1:0] m_td [NC];
    logic [XLEN-1:0] m_cap_a, m_cap_d;

    always #5 clk = ~clk;

    riscv_write_checker #(
        .XLEN(XLEN), .NUM_CHECKS(NC), .IDXW(IDXW), .TIMEOUT_CYCLES(TO), .TW(TW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .ign_lo(ign_lo), .ign_hi(ign_hi),
        .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data),
`ifdef WRCHK_CAPTURE_EN
        .cap_addr(cap_addr), .cap_data(cap_data),
`endif
        .busy(busy), .done(done), .pass(pass), .fail(fail), .fail_code(fail_code),
        .match_cnt(match_cnt), .cycle_cnt(cycle_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_armed = 0; m_pass = 0; m_fail = 0;
        m_code = 0; m_match = 0; m_cyc = 0;
        m_cap_a = '0; m_cap_d = '0;
        for (int i = 0; i < NC; i++) begin
            m_ta[i] = '0;
            m_td[i] = '0;
        end
    endfunction

    // One clock edge of behaviour, computed from the inputs present at that edge.
    function automatic void model_step();
        bit finished, bad, timed;
        int code;
        if (!m_armed) begin
            if (cfg_we && (int'(cfg_idx) < NC)) begin
                m_ta[cfg_idx] = cfg_addr;
                m_td[cfg_idx] = cfg_data;
            end
            if (start) begin
                m_armed = 1; m_pass = 0; m_fail = 0;
                m_code = 0; m_match = 0; m_cyc = 0;
                m_cap_a = '0; m_cap_d = '0;
            end
            return;
        end
        finished = 0; bad = 0; code = 0;
        if (mem_write && !((ign_lo <= data_adr) && (data_adr <= ign_hi))) begin
            if (data_adr == m_ta[m_match] && write_data == m_td[m_match]) begin
                m_match++;
                finished = (m_match == NC);
            end else begin
                bad  = 1;
                code = (data_adr == m_ta[m_match]) ? 1 : 2;
            end
        end
        timed = (m_cyc == TO - 1);
        if (m_cyc < TO) m_cyc++;
        if (finished) begin
            m_armed = 0; m_pass = 1;
        end else if (timed) begin
            m_armed = 0; m_fail = 1; m_code = 3;
        end else if (bad) begin
            m_armed = 0; m_fail = 1; m_code = code;
            m_cap_a = data_adr; m_cap_d = write_data;
        end
    endfunction

    task automatic check_all(input string ph);
        chk({ph, ".busy"},  busy,      m_armed);
        chk({ph, ".done"},  done,      m_pass | m_fail);
        chk({ph, ".pass"},  pass,      m_pass);
        chk({ph, ".fail"},  fail,      m_fail);
        chk({ph, ".code"},  fail_code, m_code);
        chk({ph, ".match"}, match_cnt, m_match);
        chk({ph, ".cyc"},   cycle_cnt, m_cyc);
`ifdef WRCHK_CAPTURE_EN
        chk({ph, ".capa"},  cap_addr,  m_cap_a);
        chk({ph, ".capd"},  cap_data,  m_cap_d);
`endif
    endtask

    task automatic clr_inputs();
        start = 0; cfg_we = 0; mem_write = 0;
    endtask

    task automatic step(input string ph);
        @(posedge clk);
        model_step();
        #1;
        check_all(ph);
        clr_inputs();
    endtask

    task automatic cfg(input int idx, input logic [XLEN-1:0] a, input logic [XLEN-1:0] d);
        cfg_we = 1; cfg_idx = IDXW'(idx); cfg_addr = a; cfg_data = d;
        step("cfg");
    endtask

    task automatic go();
        start = 1;
        step("start");
    endtask

    task automatic store(input logic [XLEN-1:0] a, input logic [XLEN-1:0] d);
        mem_write = 1; data_adr = a; write_data = d;
        step("store");
    endtask

    task automatic scen1(input string ph);
        cfg(0, 100, 25);
        cfg(1, 104, 7);
        ign_lo = 96; ign_hi = 96;
        go();
        store(96, $urandom);
        chk({ph, ".mid_match"}, match_cnt, 0);
        store(100, 25);
        store(104, 7);
        chk({ph, ".pass"},  pass,      1);
        chk({ph, ".match"}, match_cnt, 2);
        chk({ph, ".code"},  fail_code, 0);
    endtask

    initial begin
        logic [XLEN-1:0] pool [4];
        pool[0] = 100; pool[1] = 104; pool[2] = 108; pool[3] = 112;

        reset = 1; clr_inputs();
        cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
        ign_lo = '0; ign_hi = '0; data_adr = '0; write_data = '0;
        model_reset();
        #12;
        check_all("por");
        reset = 0;

        // 1: ignored store then in-order matches
        scen1("s1");

        // 2: data mismatch
        go();
        store(100, 26);
        chk("s2.fail",  fail,      1);
        chk("s2.code",  fail_code, 1);
        chk("s2.match", match_cnt, 0);
`ifdef WRCHK_CAPTURE_EN
        chk("s2.capa", cap_addr, 100);
        chk("s2.capd", cap_data, 26);
`endif

        // 3: unexpected address
        go();
        store(200, 25);
        chk("s3.fail", fail,      1);
        chk("s3.code", fail_code, 2);

        // 4a: timeout with no stores, counter frozen afterwards
        go();
        repeat (TO) step("s4a");
        chk("s4a.fail", fail,      1);
        chk("s4a.code", fail_code, 3);
        chk("s4a.cyc",  cycle_cnt, 16);
        repeat (2) step("s4a_hold");
        chk("s4a.frozen", cycle_cnt, 16);

        // 4b: final match lands on the timeout cycle
        go();
        store(100, 25);
        repeat (TO - 2) step("s4b");
        store(104, 7);
        chk("s4b.pass", pass,      1);
        chk("s4b.cyc",  cycle_cnt, 16);

        // 5: reset mid-run clears outputs and table
        go();
        store(100, 25);
        reset = 1;
        model_reset();
        #1;
        check_all("s5rst");
        chk("s5.busy",  busy,      0);
        chk("s5.match", match_cnt, 0);
        #2;
        reset = 0;
        go();
        store(100, 25);
        chk("s5.cleared", fail_code, 2);
        scen1("s5re");

        // 6: cfg write and start ignored while armed
        go();
        store(100, 25);
        cfg(0, 300, 1);
        go();
        chk("s6.match", match_cnt, 1);
        chk("s6.busy",  busy,      1);
        store(104, 7);
        chk("s6.pass", pass, 1);
        go();
        store(100, 25);
        chk("s6.tbl", match_cnt, 1);
        store(104, 7);
        chk("s6.pass2", pass, 1);

        // Random traffic
        for (int run = 0; run < 40; run++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int e = 0; e < NC; e++)
                    cfg(e, pool[$urandom_range(0, 3)], XLEN'($urandom_range(0, 3)));
            end
            ign_lo = XLEN'($urandom_range(96, 116));
            ign_hi = XLEN'($urandom_range(96, 116));
            go();
            for (int c = 0; c < 20; c++) begin
                int r;
                int k;
                r = $urandom_range(0, 9);
                k = (m_match < NC) ? m_match : 0;
                if (r <= 4) begin
                    mem_write = 1; data_adr = m_ta[k]; write_data = m_td[k];
                end else if (r == 5) begin
                    mem_write = 1; data_adr = m_ta[k]; write_data = m_td[k] + 1;
                end else if (r == 6) begin
                    mem_write = 1; data_adr = pool[$urandom_range(0, 3)];
                    write_data = XLEN'($urandom_range(0, 3));
                end else if (r == 8) begin
                    cfg_we = 1; cfg_idx = IDXW'($urandom_range(0, 3));
                    cfg_addr = pool[$urandom_range(0, 3)]; cfg_data = XLEN'($urandom_range(0, 3));
                end else if (r == 9) begin
                    start = 1;
                end
                step("rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_write_checker.md
Name: riscv_write_checker

Overview:
Synthesizable, parametrised store-bus checker for the RISC-V cores.
- Watches the core's data-memory write port (mem_write, data_adr, write_data).
- Compares stores in order against a programmable table of expected (address, data) pairs.
- Ignores stores that fall in a configurable address window.
- Reports pass, fail, a failure cause and a timeout, so self-check works in simulation and on FPGA without $display/$stop.

Parameters:
XLEN, 32, address/data width
NUM_CHECKS, 4, number of expected-store table entries (>=1)
IDXW, $clog2(NUM_CHECKS)+1, width of table index and match count
TIMEOUT_CYCLES, 1024, cycles allowed after arm before timeout fail (>=2)
TW, $clog2(TIMEOUT_CYCLES+1), cycle counter width

Ports:
clk  in  1  single clock, all state on posedge
reset  in  1  asynchronous, active-high
start  in  1  arm pulse
cfg_we  in  1  table write strobe
cfg_idx  in  IDXW  table entry index
cfg_addr  in  XLEN  expected store address
cfg_data  in  XLEN  expected store data
ign_lo  in  XLEN  ignore window low bound, inclusive
ign_hi  in  XLEN  ignore window high bound, inclusive
mem_write  in  1  core store strobe
data_adr  in  XLEN  core store address
write_data  in  XLEN  core store data
busy  out  1  high in ARMED
done  out  1  high in PASS or FAIL
pass  out  1  high in PASS
fail  out  1  high in FAIL
fail_code  out  2  0 none, 1 data mismatch, 2 unexpected address, 3 timeout
match_cnt  out  IDXW  table entries matched so far
cycle_cnt  out  TW  cycles spent in ARMED

Behaviour:
- Reset (async assert): state IDLE. All outputs 0. Table entries cleared to 0. Reset mid-ARMED aborts with no pass/fail indication.
- States are IDLE, ARMED, PASS, FAIL. Outputs are registered from state and counters.
- cfg_we: accepted in IDLE/PASS/FAIL and written at posedge. Ignored in ARMED. cfg_idx >= NUM_CHECKS is ignored.
- start in IDLE/PASS/FAIL: next cycle goes to ARMED with match_cnt=0, cycle_cnt=0, fail_code=0. start in ARMED is ignored.
- ARMED, every cycle: cycle_cnt increments, saturating at TIMEOUT_CYCLES.
- ARMED, when mem_write=1, in priority order:
  - ign_lo <= data_adr <= ign_hi (unsigned): store ignored. If ign_lo > ign_hi the window is empty.
  - data_adr == exp_addr[match_cnt] and write_data == exp_data[match_cnt]: match_cnt++. If this was entry NUM_CHECKS-1, go to PASS next cycle.
  - data_adr == exp_addr[match_cnt] but data differs: FAIL, code 1.
  - Any other address: FAIL, code 2.
- Timeout: in ARMED with cycle_cnt == TIMEOUT_CYCLES-1 and no completing match that cycle, go to FAIL with code 3. A final match on the timeout cycle wins (PASS).
- Latency: the offending or completing store is sampled at posedge N; done/pass/fail are visible after posedge N (one-cycle registered).
- PASS and FAIL are sticky until reset or start. match_cnt and cycle_cnt freeze there.
- mem_write in IDLE/PASS/FAIL has no effect.

Optional Feature:
WRCHK_CAPTURE_EN
- Defined: adds output ports cap_addr [XLEN] and cap_data [XLEN]. They latch data_adr/write_data of the store that caused FAIL code 1 or 2. They hold 0 after reset, are cleared on start, and stay unchanged on timeout.
- Undefined: ports and registers are absent. Behaviour is otherwise identical.

Decomposition:
- Package wrchk_pkg:
  - state enum wrchk_state_e {IDLE, ARMED, PASS, FAIL}
  - fail code enum wrchk_fail_e {FC_NONE, FC_DATA, FC_ADDR, FC_TIMEOUT}
  - localparam widths for fail_code
- One sub-module, wrchk_timeout_ctr:
  - saturating cycle counter with clear and enable
  - outputs cnt and expired (cnt == TIMEOUT_CYCLES-1)

Test Plan:
1. NUM_CHECKS=2, table {(100,25),(104,7)}, window 96..96. Stores (96,x), (100,25), (104,7) -> pass=1, match_cnt=2, fail_code=0 one cycle after the last store.
2. Same table. Store (100,26) -> fail=1, fail_code=1, match_cnt=0. With WRCHK_CAPTURE_EN, cap_addr=100 and cap_data=26.
3. Same table. Store (200,25) -> fail=1, fail_code=2.
4. TIMEOUT_CYCLES=16, no stores after start -> fail=1, fail_code=3, cycle_cnt=16 frozen. Also: final match on cycle 15 -> pass=1.
5. Assert reset mid-ARMED after one match -> all outputs 0 immediately, table cleared. Reprogram and restart -> scenario 1 passes again.
6. cfg_we to idx 0 while ARMED -> table unchanged and run still passes. start while ARMED -> no restart, match_cnt keeps its value.
